cache_copy_dma: RTL and testbench

Block-copy engine that acts as an initiator on the pipeline-side cache request interface (`cache_req_*` / `cache_res_*`), the same interface the datapath's memory stage drives. Given a source address, destination address and word count, it reads each 32-bit word through the cache and writes it back to the destination, honouring `cache_res_stall` exactly as the pipeline does. It lets a bench or a future multi-master arbiter exercise the cache and the latency RAM without a CPU.

---
 rtl/cache_copy_dma.sv | 132 +++++++++++++
 tb/tb_cache_copy_dma.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_copy_dma.sv
`default_nettype none
// ============================================================================
// Module   : cache_copy_dma
// Brief    : Block-copy engine issuing read/write word requests on the
//            pipeline-side cache interface, honouring cache_res_stall.
// Revision : 1.0 - initial release
// ============================================================================
module cache_copy_dma #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [31:0]            src_addr,
    input  logic [31:0]            dst_addr,
    input  logic [COUNT_WIDTH-1:0] word_count,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] words_done,
    output logic [31:0]            cache_req_addr,
    output logic [31:0]            cache_req_data,
    output logic                   cache_req_wen,
    output logic                   cache_req_valid,
    input  logic [31:0]            cache_res_data,
    input  logic                   cache_res_stall
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [31:0]            r_src;
    logic [31:0]            r_dst;
    logic [31:0]            r_buf;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] r_idx;
    logic [COUNT_WIDTH-1:0] w_idx_inc;
    logic [31:0]            w_offset;

    assign w_idx_inc  = r_idx + COUNT_WIDTH'(1);
    assign w_offset   = 32'(r_idx) << 2;
    // The word index doubles as the progress counter.
    assign words_done = r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_buf   <= '0;
            r_count <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src   <= {src_addr[31:2], 2'b00};
                        r_dst   <= {dst_addr[31:2], 2'b00};
                        r_count <= word_count;
                        r_idx   <= '0;
                    end
                end
                S_READ: begin
                    if (!cache_res_stall) begin
                        r_buf <= cache_res_data;
                    end
                end
                S_WRITE: begin
                    if (!cache_res_stall) begin
                        r_idx <= w_idx_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Request outputs derive only from registered state, so they stay
    // bit-stable for as long as the cache stalls.
    always_comb begin
        w_state_nxt     = r_state;
        busy            = 1'b1;
        done            = 1'b0;
        cache_req_valid = 1'b0;
        cache_req_wen   = 1'b0;
        cache_req_addr  = '0;
        cache_req_data  = '0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = (word_count == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                cache_req_valid = 1'b1;
                cache_req_addr  = r_src + w_offset;
                if (!cache_res_stall) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                cache_req_valid = 1'b1;
                cache_req_wen   = 1'b1;
                cache_req_addr  = r_dst + w_offset;
                cache_req_data  = r_buf;
                if (!cache_res_stall) begin
                    w_state_nxt = (w_idx_inc == r_count) ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_copy_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_copy_dma
// Brief    : Directed self-checking bench for cache_copy_dma against a
//            word-addressed memory model with programmable stall.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_copy_dma;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   src_addr;
    logic [31:0]   dst_addr;
    logic [CW-1:0] word_count;
    logic          busy;
    logic          done;
    logic [CW-1:0] words_done;
    logic [31:0]   cache_req_addr;
    logic [31:0]   cache_req_data;
    logic          cache_req_wen;
    logic          cache_req_valid;
    logic [31:0]   cache_res_data;
    logic          cache_res_stall;

    always #5 clk = ~clk;

    cache_copy_dma #(.COUNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .src_addr        (src_addr),
        .dst_addr        (dst_addr),
        .word_count      (word_count),
        .busy            (busy),
        .done            (done),
        .words_done      (words_done),
        .cache_req_addr  (cache_req_addr),
        .cache_req_data  (cache_req_data),
        .cache_req_wen   (cache_req_wen),
        .cache_req_valid (cache_req_valid),
        .cache_res_data  (cache_res_data),
        .cache_res_stall (cache_res_stall)
    );

    // Memory model: 1024 words, aliased on address bits [11:2].
    logic [31:0] mem [0:1023];
    logic        pl_en;
    logic [9:0]  pl_idx;
    logic [31:0] pl_data;
    assign cache_res_data = mem[cache_req_addr[11:2]];

    logic [31:0] log_addr [0:255];
    logic        log_wen  [0:255];
    logic [31:0] log_data [0:255];
    int          log_cnt   = 0;
    int          stall_cyc = 0;
    int          done_cnt  = 0;
    int          busy_cyc  = 0;
    int          stab_viol = 0;
    logic        p_hold    = 1'b0;
    logic [31:0] p_addr, p_data;
    logic        p_wen;

    // Inputs change just after posedge, so negedge sees what the next edge sees.
    always @(negedge clk) begin
        if (pl_en) mem[pl_idx] = pl_data;
        if (p_hold && (!cache_req_valid || cache_req_addr !== p_addr ||
                       cache_req_wen !== p_wen || cache_req_data !== p_data))
            stab_viol++;
        p_hold = cache_req_valid && cache_res_stall && !rst;
        p_addr = cache_req_addr;
        p_data = cache_req_data;
        p_wen  = cache_req_wen;
        if (done) done_cnt++;
        if (busy) busy_cyc++;
        if (cache_req_valid && cache_res_stall && !rst) stall_cyc++;
        if (cache_req_valid && !cache_res_stall && !rst) begin
            if (log_cnt < 256) begin
                log_addr[log_cnt] = cache_req_addr;
                log_wen[log_cnt]  = cache_req_wen;
                log_data[log_cnt] = cache_req_data;
            end
            log_cnt++;
            if (cache_req_wen) mem[cache_req_addr[11:2]] = cache_req_data;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [9:0] idx, input logic [31:0] d);
        pl_idx  = idx;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        #1;
        pl_en   = 1'b0;
    endtask

    // Launch a transfer and wait for done; cyc counts cycles after the start edge.
    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [CW-1:0] n,
                       input logic [7:0] spat, output int cyc);
        src_addr = s;
        dst_addr = d;
        word_count = n;
        start = 1'b1;
        cache_res_stall = 1'b0;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 300) begin
            cache_res_stall = spat[cyc % 8];
            tick();
            cyc++;
        end
        cache_res_stall = 1'b0;
        if (!done) chk("timeout_done", 32'(done), 32'd1);
    endtask

    int cyc, b0, l0, d0, s0;
    logic [31:0] e;

    initial begin
        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; word_count = '0;
        cache_res_stall = 1'b0; pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        for (int k = 0; k < 4; k++) load(10'(32'h40 + k), 32'hA0 + k);
        load(10'h3FF, 32'hC0);
        load(10'h000, 32'hC1);
        tick(); tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(cache_req_valid), 0);
        chk("rst_wen", 32'(cache_req_wen), 0);
        chk("rst_addr", cache_req_addr, 0);
        chk("rst_data", cache_req_data, 0);
        chk("rst_words_done", 32'(words_done), 0);
        rst = 1'b0;

        // Zero-length transfer
        b0 = busy_cyc; l0 = log_cnt; d0 = done_cnt;
        run(32'h100, 32'h200, 0, 8'h00, cyc);
        chk("n0_cycles", 32'(cyc), 1);
        chk("n0_valid", 32'(cache_req_valid), 0);
        tick();
        chk("n0_busy_after", 32'(busy), 0);
        chk("n0_busy_cycles", 32'(busy_cyc - b0), 1);
        chk("n0_done_pulses", 32'(done_cnt - d0), 1);
        chk("n0_requests", 32'(log_cnt - l0), 0);

        // Four words, no stall
        b0 = busy_cyc; l0 = log_cnt;
        run(32'h100, 32'h200, 4, 8'h00, cyc);
        chk("n4_cycles", 32'(cyc), 9);
        chk("n4_words_done", 32'(words_done), 4);
        tick();
        chk("n4_busy_cycles", 32'(busy_cyc - b0), 9);
        chk("n4_requests", 32'(log_cnt - l0), 8);
        for (int k = 0; k < 8; k++) begin
            e = ((k % 2) != 0) ? 32'h200 : 32'h100;
            e = e + 32'(4 * (k / 2));
            chk("n4_seq_addr", log_addr[l0 + k], e);
            chk("n4_seq_wen", 32'(log_wen[l0 + k]), 32'(k % 2));
        end
        for (int w = 0; w < 4; w++) chk("n4_dst_data", mem[32'h80 + w], 32'hA0 + w);

        // Four words with stalls
        s0 = stall_cyc;
        run(32'h100, 32'h300, 4, 8'b0110_1101, cyc);
        chk("stall_cycles", 32'(cyc), 32'(9 + stall_cyc - s0));
        chk("stall_seen", 32'(stall_cyc - s0 > 0), 1);
        chk("stall_stability", 32'(stab_viol), 0);
        for (int w = 0; w < 4; w++) chk("stall_dst_data", mem[32'hC0 + w], 32'hA0 + w);
        tick();

        // Misaligned addresses
        l0 = log_cnt;
        run(32'h103, 32'h202, 1, 8'h00, cyc);
        chk("mis_src", log_addr[l0], 32'h100);
        chk("mis_dst", log_addr[l0 + 1], 32'h200);
        chk("mis_data", log_data[l0 + 1], 32'hA0);
        tick();

        // Source wrap past the top of the address space
        l0 = log_cnt;
        run(32'hFFFF_FFFC, 32'h500, 2, 8'h00, cyc);
        chk("wrap_rd0", log_addr[l0], 32'hFFFF_FFFC);
        chk("wrap_rd1", log_addr[l0 + 2], 32'h0);
        chk("wrap_data0", mem[32'h140], 32'hC0);
        chk("wrap_data1", mem[32'h141], 32'hC1);
        tick();

        // Start re-pulsed mid-transfer is ignored
        l0 = log_cnt;
        src_addr = 32'h100; dst_addr = 32'h600; word_count = 3; start = 1'b1;
        tick();
        start = 1'b0; cyc = 1;
        tick(); tick(); cyc = 3;
        src_addr = 32'h700; dst_addr = 32'h700; word_count = 1; start = 1'b1;
        tick();
        start = 1'b0; cyc = 4;
        while (!done && cyc < 300) begin tick(); cyc++; end
        chk("repulse_cycles", 32'(cyc), 7);
        chk("repulse_words_done", 32'(words_done), 3);
        chk("repulse_requests", 32'(log_cnt - l0), 6);
        chk("repulse_rd2", log_addr[l0 + 4], 32'h108);
        chk("repulse_wr2", log_addr[l0 + 5], 32'h608);
        tick();

        // Reset during a stalled write
        d0 = done_cnt;
        src_addr = 32'h100; dst_addr = 32'h680; word_count = 2; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        cache_res_stall = 1'b1;
        tick(); tick();
        chk("wstall_wen", 32'(cache_req_wen), 1);
        chk("wstall_addr", cache_req_addr, 32'h680);
        rst = 1'b1;
        tick();
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_done", 32'(done), 0);
        chk("mrst_valid", 32'(cache_req_valid), 0);
        chk("mrst_wen", 32'(cache_req_wen), 0);
        chk("mrst_addr", cache_req_addr, 0);
        chk("mrst_data", cache_req_data, 0);
        chk("mrst_words_done", 32'(words_done), 0);
        rst = 1'b0; cache_res_stall = 1'b0;
        tick(); tick();
        chk("mrst_no_done", 32'(done_cnt - d0), 0);
        run(32'h104, 32'h700, 1, 8'h00, cyc);
        chk("post_rst_cycles", 32'(cyc), 3);
        chk("post_rst_words_done", 32'(words_done), 1);
        chk("post_rst_data", mem[32'h1C0], 32'hA1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
